// File: rtl/sysmanage_pkg.sv
// Shared types and constants for the system-manage command arbiter.
// Holds the FSM state encoding, default parameters and the opcode set.
`timescale 1ns/1ps
package sysmanage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int DEF_NCH     = 4;
    localparam int DEF_CMD_W   = 8;
    localparam int DEF_TIMEOUT = 255;

    // Opcodes occupy the low byte of a command regardless of CMD_W.
    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_STATUS    = 8'h01;
    localparam logic [7:0] OP_CLR_FAULT = 8'h02;
    localparam logic [7:0] OP_PWR_DOWN  = 8'h10;
    localparam logic [7:0] OP_PWR_UP    = 8'h11;
    localparam logic [7:0] OP_RESET_SUB = 8'h20;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sysmanage_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr_i,
// wrapping past the top channel back to channel 0.
`timescale 1ns/1ps
module sysmanage_rr_arb
    import sysmanage_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int ID_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NCH-1:0]  gnt_o,
    output logic [ID_W-1:0] gnt_idx_o
);

    logic [ID_W:0] pos;
    logic          found;

    // One extra bit on pos lets ptr+offset exceed NCH before the wrap.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        pos       = '0;
        for (int i = 0; i < NCH; i++) begin
            pos = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (pos >= (ID_W+1)'(NCH)) begin
                pos = pos - (ID_W+1)'(NCH);
            end
            if (!found && req_i[pos[ID_W-1:0]]) begin
                found                  = 1'b1;
                gnt_o[pos[ID_W-1:0]]   = 1'b1;
                gnt_idx_o              = pos[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sysmanage_arbiter.sv
// Round-robin arbiter funnelling NCH command channels into one
// system-manage slave, one transaction at a time, with a timeout.
`timescale 1ns/1ps
module sysmanage_arbiter
    import sysmanage_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int CMD_W   = DEF_CMD_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W   = $clog2(NCH)
) (
    input  logic                 clk_i,
    input  logic                 arst_n,
    input  logic [NCH-1:0]       m_valid_i,
    output logic [NCH-1:0]       m_ready_o,
    input  logic [NCH*CMD_W-1:0] m_command_i,
    output logic [NCH-1:0]       m_done_o,
    output logic [NCH-1:0]       m_err_o,
    output logic                 s_valid_o,
    input  logic                 s_ready_i,
    output logic [CMD_W-1:0]     s_command_o,
    output logic [ID_W-1:0]      s_src_o,
    input  logic                 s_done_i
);

    // Sized so TIMEOUT itself is representable and TIMEOUT=0 still gets one bit.
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    state_e             state_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [ID_W-1:0]    src_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               s_valid_q;
    logic [NCH-1:0]     done_q;
    logic [NCH-1:0]     err_q;

    logic [NCH-1:0]     gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic [CMD_W-1:0]   sel_cmd;
    logic [NCH-1:0]     src_oh;
    logic               timeout_hit;

    sysmanage_rr_arb #(
        .NCH  (NCH),
        .ID_W (ID_W)
    ) u_rr_arb (
        .req_i     (m_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        sel_cmd = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_idx == ID_W'(k)) begin
                sel_cmd = m_command_i[k*CMD_W +: CMD_W];
            end
        end
    end

    assign src_oh      = {{(NCH-1){1'b0}}, 1'b1} << src_q;
    assign rr_ptr_d    = ID_W'(wrap_inc(32'(src_q), NCH));
    assign cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // Fires on the edge where the counter reaches TIMEOUT, so the error and
    // the dropped s_valid_o are visible in the cycle the count equals TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));

    // Gating with arst_n keeps the accept low while reset is held.
    assign m_ready_o   = (state_q == IDLE && arst_n) ? gnt_oh : '0;

    assign s_valid_o   = s_valid_q;
    assign s_command_o = cmd_q;
    assign s_src_o     = src_q;
    assign m_done_o    = done_q;
    assign m_err_o     = err_q;

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            src_q     <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            s_valid_q <= 1'b0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (|m_valid_i) begin
                        cmd_q     <= sel_cmd;
                        src_q     <= gnt_idx;
                        cnt_q     <= '0;
                        s_valid_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_d;
                    if (s_ready_i && s_done_i) begin
                        done_q    <= src_oh;
                        rr_ptr_q  <= rr_ptr_d;
                        s_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (timeout_hit) begin
                        err_q     <= src_oh;
                        rr_ptr_q  <= rr_ptr_d;
                        s_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (s_ready_i) begin
                        s_valid_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (s_done_i) begin
                        done_q   <= src_oh;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end else if (timeout_hit) begin
                        err_q    <= src_oh;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    s_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    a_single_pulse: assert property (@(posedge clk_i) disable iff (!arst_n)
        $onehot0(m_done_o | m_err_o) && !(|m_done_o && |m_err_o));

    a_ready_idle_only: assert property (@(posedge clk_i) disable iff (!arst_n)
        (state_q != IDLE) |-> (m_ready_o == '0));

    a_issue_stable: assert property (@(posedge clk_i) disable iff (!arst_n)
        (s_valid_o && !s_ready_i) |=> ($stable(s_command_o) && $stable(s_src_o)));

endmodule

// File: tb/tb_sysmanage_arbiter.sv
// Randomized bench for sysmanage_arbiter against a transaction-level model,
// plus directed passes for round-robin order, direct completion, timeout and reset.
`timescale 1ns/1ps
module tb_sysmanage_arbiter;
    import sysmanage_pkg::*;

    localparam int NCH     = 4;
    localparam int CMD_W   = 8;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = 2;

    logic                 clk_i = 1'b0;
    logic                 arst_n = 1'b0;
    logic [NCH-1:0]       m_valid_i = '0;
    logic [NCH-1:0]       m_ready_o;
    logic [NCH*CMD_W-1:0] m_command_i = '0;
    logic [NCH-1:0]       m_done_o;
    logic [NCH-1:0]       m_err_o;
    logic                 s_valid_o;
    logic                 s_ready_i = 1'b0;
    logic [CMD_W-1:0]     s_command_o;
    logic [ID_W-1:0]      s_src_o;
    logic                 s_done_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference state: who owns the slave, whether the
    // command was taken, how long it has been outstanding, and pending pulses.
    int         mBusy, mHs, mSrc, mAge, mPtr, mPendDone, mPendErr;
    logic [7:0] mCmd;

    always #5 clk_i = ~clk_i;

    sysmanage_arbiter #(
        .NCH     (NCH),
        .CMD_W   (CMD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .arst_n      (arst_n),
        .m_valid_i   (m_valid_i),
        .m_ready_o   (m_ready_o),
        .m_command_i (m_command_i),
        .m_done_o    (m_done_o),
        .m_err_o     (m_err_o),
        .s_valid_o   (s_valid_o),
        .s_ready_i   (s_ready_i),
        .s_command_o (s_command_o),
        .s_src_o     (s_src_o),
        .s_done_i    (s_done_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int i = 0; i < NCH; i++) begin
            int k;
            k = (ptr + i) % NCH;
            if (v[k[1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mBusy = 0; mHs = 0; mSrc = 0; mAge = 0; mPtr = 0;
        mPendDone = -1; mPendErr = -1; mCmd = '0;
    endtask

    // Advances the model across one rising edge using the inputs held at it.
    task automatic modelEdge();
        int g;
        bit finished;
        if (!arst_n) return;
        mPendDone = -1;
        mPendErr  = -1;
        if (mBusy == 0) begin
            g = pick(m_valid_i, mPtr);
            if (g >= 0) begin
                mBusy = 1; mHs = 0; mSrc = g; mAge = 0;
                mCmd  = m_command_i[g*CMD_W +: CMD_W];
            end
        end else begin
            mAge++;
            finished = (mHs != 0) ? s_done_i : (s_ready_i && s_done_i);
            if (finished) begin
                mPendDone = mSrc; mBusy = 0; mPtr = (mSrc + 1) % NCH;
            end else if (mAge == TIMEOUT) begin
                mPendErr = mSrc; mBusy = 0; mPtr = (mSrc + 1) % NCH;
            end else if (mHs == 0 && s_ready_i) begin
                mHs = 1;
            end
        end
    endtask

    task automatic compareAll();
        int g;
        logic [3:0] expReady;
        g = pick(m_valid_i, mPtr);
        expReady = (mBusy == 0 && g >= 0) ? 4'(1 << g) : 4'b0;
        checkOutput("m_ready", 32'(m_ready_o), 32'(expReady));
        checkOutput("s_valid", 32'(s_valid_o), (mBusy != 0 && mHs == 0) ? 32'd1 : 32'd0);
        if (mBusy != 0 && mHs == 0) begin
            checkOutput("s_src", 32'(s_src_o), 32'(mSrc));
            checkOutput("s_command", 32'(s_command_o), 32'(mCmd));
        end
        checkOutput("m_done", 32'(m_done_o), (mPendDone >= 0) ? 32'(1 << mPendDone) : 32'd0);
        checkOutput("m_err", 32'(m_err_o), (mPendErr >= 0) ? 32'(1 << mPendErr) : 32'd0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_m_ready", 32'(m_ready_o), 32'd0);
        checkOutput("rst_s_valid", 32'(s_valid_o), 32'd0);
        checkOutput("rst_s_command", 32'(s_command_o), 32'd0);
        checkOutput("rst_s_src", 32'(s_src_o), 32'd0);
        checkOutput("rst_m_done", 32'(m_done_o), 32'd0);
        checkOutput("rst_m_err", 32'(m_err_o), 32'd0);
    endtask

    task automatic driveInputs(input logic [3:0] v, input logic r, input logic d, input logic [31:0] cmds);
        m_valid_i   = v;
        s_ready_i   = r;
        s_done_i    = d;
        m_command_i = cmds;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic r, input logic d, input logic [31:0] cmds);
        @(posedge clk_i);
        modelEdge();
        #1;
        driveInputs(v, r, d, cmds);
        @(negedge clk_i);
        compareAll();
    endtask

    task automatic releaseReset(input logic [3:0] v, input logic r, input logic d, input logic [31:0] cmds);
        @(posedge clk_i);
        #1;
        arst_n = 1'b1;
        driveInputs(v, r, d, cmds);
        @(negedge clk_i);
        compareAll();
    endtask

    task automatic assertReset();
        #2;
        arst_n = 1'b0;
        #1;
        modelReset();
        checkResetOutputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pctR[4];
        int pctD[4];
        logic [3:0] v;
        pctR = '{90, 20, 0, 100};
        pctD = '{50, 10, 0, 100};

        modelReset();
        driveInputs(4'hF, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkResetOutputs();

        // All channels requesting from reset: 0,1,2,3 then wrap to 0.
        releaseReset(4'hF, 1'b1, 1'b1, $urandom);
        checkOutput("rr_first", 32'(m_ready_o), 32'h1);
        for (int n = 1; n <= 4; n++) begin
            applyStimulus(4'hF, 1'b1, 1'b1, $urandom);
            applyStimulus(4'hF, 1'b1, 1'b1, $urandom);
            checkOutput("rr_order", 32'(m_ready_o), 32'(1 << (n % 4)));
            checkOutput("rr_done", 32'(m_done_o), 32'(1 << ((n - 1) % 4)));
        end

        // ch2 with 0x5A, slave takes and completes in the same cycle.
        assertReset();
        releaseReset(4'b0100, 1'b1, 1'b1, 32'h005A_0000);
        checkOutput("ch2_ready", 32'(m_ready_o), 32'h4);
        applyStimulus(4'b0000, 1'b1, 1'b1, 32'h0);
        checkOutput("ch2_s_valid", 32'(s_valid_o), 32'd1);
        checkOutput("ch2_s_src", 32'(s_src_o), 32'd2);
        checkOutput("ch2_s_command", 32'(s_command_o), 32'h5A);
        applyStimulus(4'hF, 1'b0, 1'b0, {OP_PWR_DOWN, OP_CLR_FAULT, OP_STATUS, OP_PWR_UP});
        checkOutput("ch2_done", 32'(m_done_o), 32'h4);
        checkOutput("ch2_next_ptr", 32'(m_ready_o), 32'h8);

        // ch3 now issuing with the slave never ready: timeout after 8 cycles.
        for (int n = 0; n < TIMEOUT; n++) begin
            applyStimulus(4'h0, 1'b0, 1'b0, 32'h0);
            checkOutput("to_s_valid_held", 32'(s_valid_o), 32'd1);
        end
        applyStimulus(4'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("to_s_valid_drop", 32'(s_valid_o), 32'd0);
        checkOutput("to_err", 32'(m_err_o), 32'h8);
        checkOutput("to_no_done", 32'(m_done_o), 32'd0);
        applyStimulus(4'b1001, 1'b0, 1'b0, {8'h00, 8'h00, 8'h00, OP_RESET_SUB});
        checkOutput("to_err_single", 32'(m_err_o), 32'd0);
        checkOutput("to_wrap_grant", 32'(m_ready_o), 32'h1);

        // Reset while waiting for completion, then a clean transaction.
        applyStimulus(4'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(4'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("wait_s_valid", 32'(s_valid_o), 32'd0);
        assertReset();
        s_done_i = 1'b1;
        releaseReset(4'b0010, 1'b1, 1'b1, {8'h00, 8'h00, OP_NOP, 8'h00});
        checkOutput("post_rst_ready", 32'(m_ready_o), 32'h2);
        applyStimulus(4'h0, 1'b1, 1'b1, 32'h0);
        applyStimulus(4'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("post_rst_done", 32'(m_done_o), 32'h2);

        // Randomized traffic under several slave behaviours.
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 120; c++) begin
                v = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
                applyStimulus(v, ($urandom_range(0, 99) < pctR[p]),
                              ($urandom_range(0, 99) < pctD[p]), $urandom);
                if (p == 1 && c == 60) begin
                    assertReset();
                    releaseReset(4'($urandom), 1'b1, 1'b0, $urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
